// File: rtl/mux_n_in_reg.sv
// mux_n_in_reg: registered N-input selector with a valid/ready handshake on both sides.
// One result per cycle of throughput. An out-of-range select loads input 0.
//
// Optional feature: define MUX_N_IN_REG_ERRO_EN to build the sticky out-of-range
// flag (erro) and the saturating 8-bit counter (num_erros). Without the macro,
// both outputs are tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   entradas     NUM_ENTRADAS*LARGURA flattened inputs; input k at [k*LARGURA +: LARGURA]
//   controle     select index, sampled with the input transfer
//   in_valido    upstream offers entradas/controle this cycle
//   in_pronto    block accepts a transfer this cycle (combinational)
//   saida        registered selected data
//   saida_valida saida holds an undelivered result
//   saida_pronta downstream consumes saida this cycle
//   erro         sticky out-of-range select flag
//   num_erros    saturating count of out-of-range selects
module mux_n_in_reg #(
  parameter int unsigned LARGURA      = 32,
  parameter int unsigned NUM_ENTRADAS = 5,
  parameter int unsigned SEL_W        = $clog2(NUM_ENTRADAS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]                controle,
  input  logic                            in_valido,
  output logic                            in_pronto,
  output logic [LARGURA-1:0]              saida,
  output logic                            saida_valida,
  input  logic                            saida_pronta,
  output logic                            erro,
  output logic [7:0]                      num_erros
);

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  estado_t              estado;
  logic                 transfer;
  logic [LARGURA-1:0]   dado_sel;

  assign saida_valida = (estado == CHEIO);
  // Ready whenever the output slot is free or is being drained this cycle.
  assign in_pronto    = !saida_valida || saida_pronta;
  assign transfer     = in_valido && in_pronto;

  // Input selection; anything not matching a legal index falls back to input 0.
  always_comb begin
    dado_sel = entradas[LARGURA-1:0];
    for (int unsigned k = 1; k < NUM_ENTRADAS; k++) begin
      if (32'(controle) == 32'(k)) begin
        dado_sel = entradas[k*LARGURA +: LARGURA];
      end
    end
  end

  // Two-state output slot: VAZIO (empty) / CHEIO (holding a result).
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= VAZIO;
      saida  <= '0;
    end else begin
      case (estado)
        VAZIO: begin
          if (transfer) begin
            estado <= CHEIO;
            saida  <= dado_sel;
          end
        end
        CHEIO: begin
          if (transfer) begin
            saida <= dado_sel;
          end else if (saida_pronta) begin
            estado <= VAZIO;
          end
        end
        default: begin
          estado <= VAZIO;
        end
      endcase
    end
  end

`ifdef MUX_N_IN_REG_ERRO_EN
  logic fora_faixa;

  assign fora_faixa = (32'(controle) >= 32'(NUM_ENTRADAS));

  // Sticky flag plus saturating counter of accepted out-of-range selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      erro      <= 1'b0;
      num_erros <= 8'h00;
    end else if (transfer && fora_faixa) begin
      erro <= 1'b1;
      if (num_erros != 8'hFF) begin
        num_erros <= num_erros + 8'd1;
      end
    end
  end
`else
  assign erro      = 1'b0;
  assign num_erros = 8'h00;
`endif

endmodule

// File: tb/tb_mux_n_in_reg.sv
// tb_mux_n_in_reg: self-checking bench for mux_n_in_reg.
// Main instance uses default parameters; a second instance uses LARGURA=8, NUM_ENTRADAS=2.
module tb_mux_n_in_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned SW = 3;
`ifdef MUX_N_IN_REG_ERRO_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N*W-1:0] entradas;
  logic [W-1:0]   ins [N];
  logic [SW-1:0]  controle;
  logic           in_valido;
  logic           in_pronto;
  logic [W-1:0]   saida;
  logic           saida_valida;
  logic           saida_pronta;
  logic           erro;
  logic [7:0]     num_erros;

  logic [15:0]    entradas1;
  logic [0:0]     controle1;
  logic           valido1;
  logic           pronto1;
  logic [7:0]     saida1;
  logic           valida1;
  logic           pronta1;
  logic           erro1;
  logic [7:0]     num_erros1;

  always_comb begin
    for (int k = 0; k < N; k++) entradas[k*W +: W] = ins[k];
  end

  mux_n_in_reg u0 (
    .clk(clk), .reset(reset), .entradas(entradas), .controle(controle),
    .in_valido(in_valido), .in_pronto(in_pronto), .saida(saida),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .erro(erro), .num_erros(num_erros)
  );

  mux_n_in_reg #(.LARGURA(8), .NUM_ENTRADAS(2)) u1 (
    .clk(clk), .reset(reset), .entradas(entradas1), .controle(controle1),
    .in_valido(valido1), .in_pronto(pronto1), .saida(saida1),
    .saida_valida(valida1), .saida_pronta(pronta1),
    .erro(erro1), .num_erros(num_erros1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference selector: out-of-range index picks input 0.
  function automatic logic [W-1:0] model_sel(input logic [SW-1:0] c);
    if (32'(c) < N) return ins[c];
    return ins[0];
  endfunction

  // Scoreboard: push on accepted transfer, pop when the output is consumed.
  logic [W-1:0] sb [$];
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (saida_valida && saida_pronta) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got 0x%08h with no expected entry at %0t", saida, $time);
        end else begin
          check("sb_data", saida, sb.pop_front());
        end
      end
      if (in_valido && in_pronto) sb.push_back(model_sel(controle));
    end
  end

  typedef struct {
    logic [SW-1:0] ctl;
    int unsigned   idx;
  } vec_t;

  vec_t        tab [8];
  logic [W-1:0] exp_d, a_d, b_d;
  int unsigned  n_err_exp;

  initial begin
    tab[0] = '{3'd0, 0}; tab[1] = '{3'd1, 1}; tab[2] = '{3'd2, 2}; tab[3] = '{3'd3, 3};
    tab[4] = '{3'd4, 4}; tab[5] = '{3'd7, 0}; tab[6] = '{3'd5, 0}; tab[7] = '{3'd2, 2};

    reset = 1'b1; in_valido = 1'b0; controle = '0; saida_pronta = 1'b0;
    for (int k = 0; k < N; k++) ins[k] = $urandom;
    entradas1 = 16'h5AC3; controle1 = 1'b0; valido1 = 1'b0; pronta1 = 1'b1;
    tick; tick;

    // Reset state
    check("rst_saida", saida, 32'h0);
    check("rst_valida", 32'(saida_valida), 32'h0);
    check("rst_erro", 32'(erro), 32'h0);
    check("rst_num_erros", 32'(num_erros), 32'h0);
    check("rst_in_pronto", 32'(in_pronto), 32'h1);
    check("rst_saida1", 32'(saida1), 32'h0);
    reset = 1'b0;

    // Single transfer, input 3
    ins[3] = 32'hDEADBEEF; controle = 3'd3; in_valido = 1'b1; saida_pronta = 1'b1;
    tick;
    check("first_saida", saida, 32'hDEADBEEF);
    check("first_valida", 32'(saida_valida), 32'h1);

    // Back-to-back table, including out-of-range selects
    n_err_exp = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) ins[k] = $urandom;
      controle = tab[i].ctl;
      exp_d = ins[tab[i].idx];
      if (32'(tab[i].ctl) >= N) n_err_exp++;
      tick;
      check($sformatf("tab%0d_saida", i), saida, exp_d);
      check($sformatf("tab%0d_valida", i), 32'(saida_valida), 32'h1);
      check($sformatf("tab%0d_in_pronto", i), 32'(in_pronto), 32'h1);
    end
    in_valido = 1'b0;
    check("tab_erro", 32'(erro), EN ? 32'h1 : 32'h0);
    check("tab_num_erros", 32'(num_erros), EN ? n_err_exp : 32'h0);
    tick;
    check("drain_valida", 32'(saida_valida), 32'h0);

    // Backpressure: hold for 3 cycles, then consume and load on the same edge
    for (int k = 0; k < N; k++) ins[k] = $urandom;
    controle = 3'd1; in_valido = 1'b1; a_d = ins[1];
    tick;
    check("bp_load_a", saida, a_d);
    saida_pronta = 1'b0; controle = 3'd2;
    for (int k = 0; k < N; k++) ins[k] = $urandom;
    b_d = ins[2];
    #1;
    check("bp_in_pronto_low", 32'(in_pronto), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check($sformatf("bp_hold%0d_saida", c), saida, a_d);
      check($sformatf("bp_hold%0d_valida", c), 32'(saida_valida), 32'h1);
      check($sformatf("bp_hold%0d_in_pronto", c), 32'(in_pronto), 32'h0);
    end
    saida_pronta = 1'b1;
    #1;
    check("bp_in_pronto_high", 32'(in_pronto), 32'h1);
    tick;
    check("bp_load_b", saida, b_d);
    check("bp_valida_b", 32'(saida_valida), 32'h1);
    in_valido = 1'b0;
    tick;
    check("bp_empty_valida", 32'(saida_valida), 32'h0);
    check("bp_empty_saida_hold", saida, b_d);
    saida_pronta = 1'b0;
    #1;
    check("empty_in_pronto", 32'(in_pronto), 32'h1);

    // Reset wins over a simultaneous transfer while CHEIO
    controle = 3'd4; in_valido = 1'b1;
    tick;
    check("pre_rst_valida", 32'(saida_valida), 32'h1);
    reset = 1'b1; controle = 3'd1; saida_pronta = 1'b1;
    #1;
    check("rst_in_pronto_follows", 32'(in_pronto), 32'h1);
    tick;
    check("rst_prio_saida", saida, 32'h0);
    check("rst_prio_valida", 32'(saida_valida), 32'h0);
    check("rst_prio_erro", 32'(erro), 32'h0);
    check("rst_prio_num_erros", 32'(num_erros), 32'h0);
    reset = 1'b0; in_valido = 1'b0;
    tick;

    // Out-of-range select and counter saturation
    for (int k = 0; k < N; k++) ins[k] = $urandom;
    controle = 3'd7; in_valido = 1'b1; saida_pronta = 1'b1;
    tick;
    check("oor_saida", saida, ins[0]);
    check("oor_erro", 32'(erro), EN ? 32'h1 : 32'h0);
    check("oor_num_erros", 32'(num_erros), EN ? 32'h1 : 32'h0);
    repeat (299) tick;
    in_valido = 1'b0;
    check("sat_num_erros", 32'(num_erros), EN ? 32'd255 : 32'h0);
    check("sat_erro", 32'(erro), EN ? 32'h1 : 32'h0);
    tick;

    // Narrow two-input instance
    controle1 = 1'b1; valido1 = 1'b1;
    tick;
    check("n2_saida_in1", 32'(saida1), 32'h5A);
    check("n2_erro_a", 32'(erro1), 32'h0);
    controle1 = 1'b0;
    tick;
    check("n2_saida_in0", 32'(saida1), 32'hC3);
    check("n2_valida", 32'(valida1), 32'h1);
    valido1 = 1'b0;
    tick;
    check("n2_drain_valida", 32'(valida1), 32'h0);
    check("n2_erro_b", 32'(erro1), 32'h0);
    check("n2_num_erros", 32'(num_erros1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_in_reg.md
MUX_N_IN_REG -- requirements
Module: mux_n_in_reg

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, data width of each input and of the output.
REQ-002 The block SHALL have parameter NUM_ENTRADAS, default 5, number of selectable inputs, legal range 2..16.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(NUM_ENTRADAS), width of controle.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port entradas  input  NUM_ENTRADAS*LARGURA  flattened inputs, input k at bits [k*LARGURA +: LARGURA].
REQ-007 The block SHALL have port controle  input  SEL_W  select index, sampled with the input transfer.
REQ-008 The block SHALL have port in_valido  input  1  upstream offers entradas/controle this cycle.
REQ-009 The block SHALL have port in_pronto  output  1  block accepts a transfer this cycle.
REQ-010 The block SHALL have port saida  output  LARGURA  registered selected data.
REQ-011 The block SHALL have port saida_valida  output  1  saida holds an undelivered result.
REQ-012 The block SHALL have port saida_pronta  input  1  downstream consumes saida this cycle.
REQ-013 The block SHALL have port erro  output  1  sticky out-of-range select flag.
REQ-014 The block SHALL have port num_erros  output  8  count of out-of-range selects.

Function
REQ-015 in_pronto SHALL equal (!saida_valida || saida_pronta), combinationally, with no dependence on in_valido.
REQ-016 An input transfer SHALL occur on a rising edge where in_valido && in_pronto; latency input transfer to saida_valida is exactly 1 cycle.
REQ-017 On a transfer, saida SHALL load input[controle] if controle < NUM_ENTRADAS, else input 0.
REQ-018 saida_valida SHALL go 1 on a transfer, and go 0 on an edge where saida_pronta && saida_valida with no transfer.
REQ-019 A simultaneous output consume and input transfer SHALL keep saida_valida at 1 and load the new data, giving 1 result per cycle of throughput.
REQ-020 With saida_valida=1 and saida_pronta=0, saida and saida_valida SHALL hold and in_pronto SHALL be 0.
REQ-021 saida SHALL change only on an input transfer; no output glitch SHALL follow changes of entradas or controle between transfers.
REQ-022 The block SHALL be a two-state machine, VAZIO (saida_valida=0) and CHEIO (saida_valida=1), with transitions as in REQ-016..REQ-020.

Reset
REQ-023 When reset=1 at a rising edge, saida SHALL become 0, saida_valida 0, erro 0 and num_erros 0; reset SHALL take priority over any transfer in the same cycle.
REQ-024 While reset=1, in_pronto SHALL still follow REQ-015, but no transfer SHALL complete.

Configuration
REQ-025 With macro MUX_N_IN_REG_ERRO_EN defined, erro SHALL set to 1 on a transfer with controle >= NUM_ENTRADAS and stay 1 until reset.
REQ-026 With MUX_N_IN_REG_ERRO_EN defined, num_erros SHALL increment on each such transfer and saturate at 255.
REQ-027 Without MUX_N_IN_REG_ERRO_EN, erro and num_erros SHALL be constant 0, no error logic SHALL be synthesised, and datapath behaviour SHALL be unchanged.

Verification
REQ-028 Defaults, reset, then in_valido=1, controle=3, input3=0xDEADBEEF, saida_pronta=1 -> next cycle saida=0xDEADBEEF, saida_valida=1.
REQ-029 Back-to-back transfers with controle=0,1,2,3,4 on consecutive cycles, saida_pronta=1 -> saida shows inputs 0..4 on 5 consecutive cycles, in_pronto stays 1.
REQ-030 saida_pronta=0 while CHEIO, with new in_valido offered -> in_pronto=0 and saida holds for 3 cycles; then saida_pronta=1 -> new data loads on the same edge.
REQ-031 controle=7 with NUM_ENTRADAS=5 and the macro defined -> saida=input0, erro=1, num_erros=1; 300 such transfers -> num_erros=255.
REQ-032 reset asserted in the same cycle as a transfer while CHEIO -> next cycle saida=0, saida_valida=0, erro=0, num_erros=0.
REQ-033 Parameters LARGURA=8, NUM_ENTRADAS=2, macro undefined, controle=1, input1=0x5A -> saida=0x5A, erro=0 throughout.
